// File: rtl/cnn_pkg.sv
// Shared CNN post-processing types and the requantization helper.
// Build option: POOL_ROUND_EN selects round-half-up instead of floor.
package cnn_pkg;

    localparam int CONV_W = 24;
    localparam int Q_W    = 8;
    localparam int Q_MAX  = 127;

    // Arithmetic shift on a 25-bit copy so the rounding add cannot overflow,
    // then ReLU (negative -> 0) and saturation to Q_MAX.
    function automatic logic [Q_W-1:0] requant(input logic signed [CONV_W-1:0] x,
                                               input int unsigned shift);
        logic signed [CONV_W:0] sum;
        logic signed [CONV_W:0] q;
`ifdef POOL_ROUND_EN
        sum = {x[CONV_W-1], x} + ((CONV_W+1)'(1) << (shift - 32'd1));
`else
        sum = {x[CONV_W-1], x};
`endif
        q = sum >>> shift;
        if (q[CONV_W])
            return '0;
        else if (|q[CONV_W-1:Q_W-1])
            return Q_W'(Q_MAX);
        else
            return q[Q_W-1:0];
    endfunction

endpackage

// File: rtl/conv_requant_relu.sv
// Stage 1 for one channel: round/shift, ReLU and saturate, then register.
// Rounding mode follows POOL_ROUND_EN through cnn_pkg::requant.
module conv_requant_relu
    import cnn_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CONV_W-1:0] conv_in,
    output logic [Q_W-1:0]    q_out
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q_out <= '0;
        else if (en)
            q_out <= requant(conv_in, SHIFT);
    end

endmodule

// File: rtl/conv_relu_maxpool_2ch.sv
// Two-channel requant + ReLU + 2x2 stride-2 max pool over a raster-scanned map.
// Build option: POOL_ROUND_EN (round-half-up requantization, else floor).
module conv_relu_maxpool_2ch
    import cnn_pkg::*;
#(
    parameter int IMG_W = 26,
    parameter int IMG_H = 26,
    parameter int SHIFT = 8
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [CONV_W-1:0] ch0_conv_in,
    input  logic [CONV_W-1:0] ch1_conv_in,
    output logic              out_valid,
    output logic [Q_W-1:0]    ch0_pool_out,
    output logic [Q_W-1:0]    ch1_pool_out,
    output logic              frame_done
);

    // in_valid and out_valid are valid-only strobes: there is no ready, every
    // cycle with valid high is one transfer and the consumer must accept it.

    localparam int HALF_W = IMG_W / 2;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int LBW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col, cur_col, s1_col;
    logic [RW-1:0] row, cur_row;
    logic          at_last_col, at_last_row;
    logic          s1_valid, s1_row_odd, s1_last;
    logic [Q_W-1:0] q0, q1, hmax0, hmax1, h0, h1, p0, p1;
    logic [2*Q_W-1:0] line_buf [HALF_W];
    logic [2*Q_W-1:0] lb_rd;
    logic [LBW-1:0]   lb_idx;
    logic             take;

    // frame_start makes a coincident pixel land at (0,0)
    always_comb begin
        cur_col     = frame_start ? '0 : col;
        cur_row     = frame_start ? '0 : row;
        at_last_col = (cur_col == COL_LAST);
        at_last_row = (cur_row == ROW_LAST);
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (at_last_col) begin
                col <= '0;
                row <= at_last_row ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end else if (frame_start) begin
            col <= '0;
            row <= '0;
        end
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            s1_valid   <= 1'b0;
            s1_col     <= '0;
            s1_row_odd <= 1'b0;
            s1_last    <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_col     <= cur_col;
                s1_row_odd <= cur_row[0];
                s1_last    <= at_last_col && at_last_row;
            end
        end
    end

    conv_requant_relu #(.SHIFT(SHIFT)) u_rq0 (
        .clk(sclk), .rst_n(s_rst_n), .en(in_valid), .conv_in(ch0_conv_in), .q_out(q0)
    );
    conv_requant_relu #(.SHIFT(SHIFT)) u_rq1 (
        .clk(sclk), .rst_n(s_rst_n), .en(in_valid), .conv_in(ch1_conv_in), .q_out(q1)
    );

    // A stage-1 sample seen together with frame_start belongs to the aborted frame.
    always_comb begin
        take   = s1_valid && !frame_start;
        lb_idx = LBW'(s1_col >> 1);
        lb_rd  = line_buf[lb_idx];
        h0     = (q0 > hmax0) ? q0 : hmax0;
        h1     = (q1 > hmax1) ? q1 : hmax1;
        p0     = (lb_rd[Q_W-1:0] > h0) ? lb_rd[Q_W-1:0] : h0;
        p1     = (lb_rd[2*Q_W-1:Q_W] > h1) ? lb_rd[2*Q_W-1:Q_W] : h1;
    end

    // Every entry is rewritten on an even row before an odd row reads it.
    always_ff @(posedge sclk) begin
        if (take && s1_col[0] && !s1_row_odd)
            line_buf[lb_idx] <= {h1, h0};
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            hmax0        <= '0;
            hmax1        <= '0;
            out_valid    <= 1'b0;
            ch0_pool_out <= '0;
            ch1_pool_out <= '0;
            frame_done   <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                hmax0 <= '0;
                hmax1 <= '0;
            end else if (s1_valid) begin
                frame_done <= s1_last;
                if (!s1_col[0]) begin
                    hmax0 <= q0;
                    hmax1 <= q1;
                end else if (s1_row_odd) begin
                    out_valid    <= 1'b1;
                    ch0_pool_out <= p0;
                    ch1_pool_out <= p1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_relu_maxpool_2ch.sv
// Directed bench: 4x4 instance for pooling/requant/control, 5x3 instance for odd dims.
module tb_conv_relu_maxpool_2ch;

    logic        sclk = 1'b0;
    logic        s_rst_n, frame_start, in_valid, sel;
    logic [23:0] d0, d1;
    logic        a_ov, a_fd, b_ov, b_fd, obs_ov, obs_fd;
    logic [7:0]  a_o0, a_o1, b_o0, b_o1, obs_o0, obs_o1;

    int total = 0;
    int bad   = 0;

    logic signed [23:0] px0 [64];
    logic signed [23:0] px1 [64];
    logic               pfs [64];
    logic               ov [64];
    logic               ofd [64];
    logic               ev [64];
    logic               efd [64];
    logic [7:0]         o0 [64];
    logic [7:0]         o1 [64];
    logic [7:0]         e0 [64];
    logic [7:0]         e1 [64];
    logic signed [23:0] pool0 [16];
    logic [7:0]         pe0 [4];
    logic [7:0]         pe1 [4];
    int out_cnt, fd_cnt;

    always #5 sclk = ~sclk;

    conv_relu_maxpool_2ch #(.IMG_W(4), .IMG_H(4), .SHIFT(8)) u_dut_a (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .frame_start(frame_start & ~sel), .in_valid(in_valid & ~sel),
        .ch0_conv_in(d0), .ch1_conv_in(d1),
        .out_valid(a_ov), .ch0_pool_out(a_o0), .ch1_pool_out(a_o1), .frame_done(a_fd)
    );

    conv_relu_maxpool_2ch #(.IMG_W(5), .IMG_H(3), .SHIFT(8)) u_dut_b (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .frame_start(frame_start & sel), .in_valid(in_valid & sel),
        .ch0_conv_in(d0), .ch1_conv_in(d1),
        .out_valid(b_ov), .ch0_pool_out(b_o0), .ch1_pool_out(b_o1), .frame_done(b_fd)
    );

    assign obs_ov = sel ? b_ov : a_ov;
    assign obs_fd = sel ? b_fd : a_fd;
    assign obs_o0 = sel ? b_o0 : a_o0;
    assign obs_o1 = sel ? b_o1 : a_o1;

    task automatic clear_tables();
        for (int k = 0; k < 64; k++) begin
            px0[k] = '0; px1[k] = '0; pfs[k] = 1'b0;
            ov[k] = 1'b0; ofd[k] = 1'b0; o0[k] = '0; o1[k] = '0;
            ev[k] = 1'b0; efd[k] = 1'b0; e0[k] = '0; e1[k] = '0;
        end
    endtask

    // Pixel k goes out every gap+1 cycles; its result is captured two edges later.
    task automatic drive(input int n, input int gap);
        int last, j;
        out_cnt = 0;
        fd_cnt  = 0;
        last = (n - 1) * (gap + 1);
        for (int c = 0; c <= last + 2; c++) begin
            if ((c % (gap + 1)) == 0 && (c / (gap + 1)) < n) begin
                j = c / (gap + 1);
                in_valid = 1'b1; frame_start = pfs[j]; d0 = px0[j]; d1 = px1[j];
            end else begin
                in_valid = 1'b0; frame_start = 1'b0;
            end
            @(posedge sclk); #1;
            if (obs_ov) out_cnt++;
            if (obs_fd) fd_cnt++;
            if (c >= 1 && ((c - 1) % (gap + 1)) == 0 && ((c - 1) / (gap + 1)) < n) begin
                j = (c - 1) / (gap + 1);
                ov[j] = obs_ov; ofd[j] = obs_fd; o0[j] = obs_o0; o1[j] = obs_o1;
            end
        end
        in_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0; in_valid = 1'b0; frame_start = 1'b0; sel = 1'b0; d0 = '0; d1 = '0;
        repeat (3) @(posedge sclk);
        #1;
        total++;
        if ({a_ov, a_fd, a_o0, a_o1} !== 18'd0) begin
            bad++; $display("FAIL reset_a: got %h want 0", {a_ov, a_fd, a_o0, a_o1});
        end
        total++;
        if ({b_ov, b_fd, b_o0, b_o1} !== 18'd0) begin
            bad++; $display("FAIL reset_b: got %h want 0", {b_ov, b_fd, b_o0, b_o1});
        end
        s_rst_n = 1'b1;
    endtask

    task automatic test_requant();
        logic signed [23:0] xa [4];
        logic signed [23:0] xb [4];
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        int r, c, w;
        xa = '{24'sd384, -24'sd100, 24'sd40000, 24'sd127};
        xb = '{24'sd511, 24'sd128, -24'sd1, 24'sd32767};
`ifdef POOL_ROUND_EN
        ea = '{8'd2, 8'd0, 8'd127, 8'd0};
        eb = '{8'd2, 8'd1, 8'd0, 8'd127};
`else
        ea = '{8'd1, 8'd0, 8'd127, 8'd0};
        eb = '{8'd1, 8'd0, 8'd0, 8'd127};
`endif
        clear_tables();
        for (int k = 0; k < 16; k++) begin
            r = k / 4; c = k % 4; w = (r / 2) * 2 + c / 2;
            px0[k] = xa[w]; px1[k] = xb[w]; pfs[k] = (k == 0);
            ev[k] = (c % 2 == 1) && (r % 2 == 1); e0[k] = ea[w]; e1[k] = eb[w]; efd[k] = (k == 15);
        end
        drive(16, 0);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (ov[k] !== ev[k]) begin bad++; $display("FAIL requant_valid px%0d: got %b want %b", k, ov[k], ev[k]); end
            if (ev[k]) begin
                total++;
                if (o0[k] !== e0[k] || o1[k] !== e1[k]) begin
                    bad++; $display("FAIL requant_value px%0d: got %0d/%0d want %0d/%0d", k, o0[k], o1[k], e0[k], e1[k]);
                end
            end
            total++;
            if (ofd[k] !== efd[k]) begin bad++; $display("FAIL requant_done px%0d: got %b want %b", k, ofd[k], efd[k]); end
        end
        total++;
        if (out_cnt != 4 || fd_cnt != 1) begin bad++; $display("FAIL requant_count: got %0d/%0d want 4/1", out_cnt, fd_cnt); end
    endtask

    // Two frames back to back with no frame_start: relies on counter wrap.
    task automatic test_back_to_back();
        int rel, w;
        clear_tables();
        for (int k = 0; k < 32; k++) begin
            rel = k % 16; w = (rel / 8) * 2 + (rel % 4) / 2;
            px0[k] = pool0[rel]; px1[k] = pool0[rel] * 2;
            ev[k] = (rel % 2 == 1) && ((rel / 4) % 2 == 1); e0[k] = pe0[w]; e1[k] = pe1[w]; efd[k] = (rel == 15);
        end
        drive(32, 0);
        for (int k = 0; k < 32; k++) begin
            total++;
            if (ov[k] !== ev[k]) begin bad++; $display("FAIL b2b_valid px%0d: got %b want %b", k, ov[k], ev[k]); end
            if (ev[k]) begin
                total++;
                if (o0[k] !== e0[k] || o1[k] !== e1[k]) begin
                    bad++; $display("FAIL b2b_value px%0d: got %0d/%0d want %0d/%0d", k, o0[k], o1[k], e0[k], e1[k]);
                end
            end
            total++;
            if (ofd[k] !== efd[k]) begin bad++; $display("FAIL b2b_done px%0d: got %b want %b", k, ofd[k], efd[k]); end
        end
        total++;
        if (out_cnt != 8 || fd_cnt != 2) begin bad++; $display("FAIL b2b_count: got %0d/%0d want 8/2", out_cnt, fd_cnt); end
    endtask

    task automatic test_gapped();
        int w;
        clear_tables();
        for (int k = 0; k < 16; k++) begin
            w = (k / 8) * 2 + (k % 4) / 2;
            px0[k] = pool0[k]; px1[k] = pool0[k] * 2; pfs[k] = (k == 0);
            ev[k] = (k % 2 == 1) && ((k / 4) % 2 == 1); e0[k] = pe0[w]; e1[k] = pe1[w]; efd[k] = (k == 15);
        end
        drive(16, 3);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (ov[k] !== ev[k]) begin bad++; $display("FAIL gap_valid px%0d: got %b want %b", k, ov[k], ev[k]); end
            if (ev[k]) begin
                total++;
                if (o0[k] !== e0[k] || o1[k] !== e1[k]) begin
                    bad++; $display("FAIL gap_value px%0d: got %0d/%0d want %0d/%0d", k, o0[k], o1[k], e0[k], e1[k]);
                end
            end
            total++;
            if (ofd[k] !== efd[k]) begin bad++; $display("FAIL gap_done px%0d: got %b want %b", k, ofd[k], efd[k]); end
        end
        total++;
        if (out_cnt != 4 || fd_cnt != 1) begin bad++; $display("FAIL gap_count: got %0d/%0d want 4/1", out_cnt, fd_cnt); end
    endtask

    task automatic test_frame_start();
        int rel, w;
        clear_tables();
        for (int k = 0; k < 6; k++) begin
            px0[k] = 24'sd20000; px1[k] = 24'sd20000;
        end
        for (int k = 6; k < 22; k++) begin
            rel = k - 6; w = (rel / 8) * 2 + (rel % 4) / 2;
            px0[k] = pool0[rel]; px1[k] = pool0[rel] * 2; pfs[k] = (k == 6);
            ev[k] = (rel % 2 == 1) && ((rel / 4) % 2 == 1); e0[k] = pe0[w]; e1[k] = pe1[w]; efd[k] = (k == 21);
        end
        drive(22, 0);
        for (int k = 0; k < 22; k++) begin
            total++;
            if (ov[k] !== ev[k]) begin bad++; $display("FAIL fs_valid px%0d: got %b want %b", k, ov[k], ev[k]); end
            if (ev[k]) begin
                total++;
                if (o0[k] !== e0[k] || o1[k] !== e1[k]) begin
                    bad++; $display("FAIL fs_value px%0d: got %0d/%0d want %0d/%0d", k, o0[k], o1[k], e0[k], e1[k]);
                end
            end
            total++;
            if (ofd[k] !== efd[k]) begin bad++; $display("FAIL fs_done px%0d: got %b want %b", k, ofd[k], efd[k]); end
        end
        total++;
        if (out_cnt != 4 || fd_cnt != 1) begin bad++; $display("FAIL fs_count: got %0d/%0d want 4/1", out_cnt, fd_cnt); end
    endtask

    task automatic test_mid_reset();
        int w;
        clear_tables();
        for (int k = 0; k < 6; k++) begin
            px0[k] = pool0[k]; px1[k] = pool0[k] * 2; pfs[k] = (k == 0);
        end
        drive(6, 0);
        total++;
        if (ov[5] !== 1'b1 || o0[5] !== 8'd5) begin
            bad++; $display("FAIL prereset_out: got %b/%0d want 1/5", ov[5], o0[5]);
        end
        s_rst_n = 1'b0;
        @(posedge sclk); #1;
        total++;
        if ({a_ov, a_fd, a_o0, a_o1} !== 18'd0) begin
            bad++; $display("FAIL midreset_out: got %h want 0", {a_ov, a_fd, a_o0, a_o1});
        end
        s_rst_n = 1'b1;
        clear_tables();
        for (int k = 0; k < 16; k++) begin
            w = (k / 8) * 2 + (k % 4) / 2;
            px0[k] = pool0[k]; px1[k] = -pool0[k];
            ev[k] = (k % 2 == 1) && ((k / 4) % 2 == 1); e0[k] = pe0[w]; e1[k] = 8'd0; efd[k] = (k == 15);
        end
        drive(16, 0);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (ov[k] !== ev[k]) begin bad++; $display("FAIL rst_valid px%0d: got %b want %b", k, ov[k], ev[k]); end
            if (ev[k]) begin
                total++;
                if (o0[k] !== e0[k] || o1[k] !== e1[k]) begin
                    bad++; $display("FAIL rst_value px%0d: got %0d/%0d want %0d/%0d", k, o0[k], o1[k], e0[k], e1[k]);
                end
            end
            total++;
            if (ofd[k] !== efd[k]) begin bad++; $display("FAIL rst_done px%0d: got %b want %b", k, ofd[k], efd[k]); end
        end
        total++;
        if (out_cnt != 4 || fd_cnt != 1) begin bad++; $display("FAIL rst_count: got %0d/%0d want 4/1", out_cnt, fd_cnt); end
    endtask

    // 5x3 map: last column and last row are dropped.
    task automatic test_odd_dims();
        clear_tables();
        sel = 1'b1;
        for (int k = 0; k < 15; k++) begin
            px0[k] = 24'sd1024; px1[k] = 24'sd2048;
            ev[k] = (k == 6) || (k == 8); e0[k] = 8'd4; e1[k] = 8'd8; efd[k] = (k == 14);
        end
        drive(15, 0);
        for (int k = 0; k < 15; k++) begin
            total++;
            if (ov[k] !== ev[k]) begin bad++; $display("FAIL odd_valid px%0d: got %b want %b", k, ov[k], ev[k]); end
            if (ev[k]) begin
                total++;
                if (o0[k] !== e0[k] || o1[k] !== e1[k]) begin
                    bad++; $display("FAIL odd_value px%0d: got %0d/%0d want %0d/%0d", k, o0[k], o1[k], e0[k], e1[k]);
                end
            end
            total++;
            if (ofd[k] !== efd[k]) begin bad++; $display("FAIL odd_done px%0d: got %b want %b", k, ofd[k], efd[k]); end
        end
        total++;
        if (out_cnt != 2 || fd_cnt != 1) begin bad++; $display("FAIL odd_count: got %0d/%0d want 2/1", out_cnt, fd_cnt); end
        sel = 1'b0;
    endtask

    initial begin
        pool0 = '{24'sd256, 24'sd512, 24'sd768, 24'sd1024,
                  24'sd1280, 24'sd0, 24'sd0, 24'sd256,
                  24'sd0, 24'sd768, 24'sd1280, 24'sd0,
                  24'sd256, 24'sd256, 24'sd0, 24'sd512};
        pe0 = '{8'd5, 8'd4, 8'd3, 8'd5};
        pe1 = '{8'd10, 8'd8, 8'd6, 8'd10};
        test_reset();
        test_requant();
        test_back_to_back();
        test_gapped();
        test_frame_start();
        test_mid_reset();
        test_odd_dims();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
